// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit processor. It sequences fetch, decode, execute, memory and write-back.
// Every output is registered from the next state and the next IR, so all outputs are Moore outputs.
module multicycle_ctrl_fsm #(
    parameter int DATA_W     = 16,
    parameter int OPCODE_W   = 4,
    parameter int REG_ADDR_W = 4,
    parameter int ALU_OP_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     instr,
    output logic                  imem_req,
    input  logic                  imem_ready,
    input  logic                  alu_lt,
    input  logic                  alu_eq,
    output logic                  alu_start,
    input  logic                  alu_done,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ready,
    output logic [REG_ADDR_W-1:0] reg_addr_a,
    output logic [REG_ADDR_W-1:0] reg_addr_b,
    output logic [REG_ADDR_W-1:0] reg_addr_c,
    output logic                  reg_we,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  im_en,
    output logic                  wb_sel,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic                  illegal_op,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC     = 3'd3,
        S_ALU_WAIT = 3'd4,
        S_MEM      = 3'd5,
        S_WB       = 3'd6,
        S_TAKEN    = 3'd7
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBI = 4'd3;
    localparam logic [3:0] OP_MULT = 4'd4;
    localparam logic [3:0] OP_SW   = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_LT   = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_MOD  = 4'd10;
    localparam logic [3:0] OP_LTE  = 4'd11;
    localparam logic [3:0] OP_BLT  = 4'd12;
    localparam logic [3:0] OP_BGE  = 4'd13;
    localparam logic [3:0] OP_BEQ  = 4'd14;
    localparam logic [3:0] OP_JUMP = 4'd15;

    typedef struct packed {
        logic                  imem_req;
        logic                  alu_start;
        logic                  dmem_req;
        logic                  dmem_we;
        logic [REG_ADDR_W-1:0] addr_a;
        logic [REG_ADDR_W-1:0] addr_b;
        logic [REG_ADDR_W-1:0] addr_c;
        logic                  reg_we;
        logic [ALU_OP_W-1:0]   alu_op;
        logic                  im_en;
        logic                  wb_sel;
        logic                  pc_inc;
        logic                  pc_load;
        logic                  illegal_op;
    } ctrl_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATA_W-1:0]   ir_r;
    logic [DATA_W-1:0]   ir_nxt_s;
    ctrl_t               ctrl_r;
    ctrl_t               ctrl_nxt_s;
    logic [3:0]          op_s;
    logic                illegal_s;

    // Only opcodes 0..15 exist; any set bit above the low nibble is undefined.
    function automatic logic is_illegal(input logic [DATA_W-1:0] ir);
        logic [OPCODE_W-1:0] opc;
        opc = ir[DATA_W-1 -: OPCODE_W];
        return (opc >> 3'd4) != {OPCODE_W{1'b0}};
    endfunction

    function automatic logic [3:0] op_low(input logic [DATA_W-1:0] ir);
        logic [OPCODE_W-1:0] opc;
        opc = ir[DATA_W-1 -: OPCODE_W];
        return opc[3:0];
    endfunction

    function automatic logic [ALU_OP_W-1:0] alu_op_of(input logic [3:0] op);
        logic [ALU_OP_W-1:0] res;
        case (op)
            OP_SUB, OP_SUBI:                res = ALU_OP_W'(3'd1);
            OP_MULT:                        res = ALU_OP_W'(3'd2);
            OP_NAND:                        res = ALU_OP_W'(3'd3);
            OP_DIV:                         res = ALU_OP_W'(3'd4);
            OP_MOD:                         res = ALU_OP_W'(3'd5);
            OP_LT, OP_BLT, OP_BGE, OP_BEQ:  res = ALU_OP_W'(3'd6);
            OP_LTE:                         res = ALU_OP_W'(3'd7);
            default:                        res = ALU_OP_W'(3'd0);
        endcase
        return res;
    endfunction

    function automatic ctrl_t ctrl_of(input state_t st, input logic [DATA_W-1:0] ir);
        ctrl_t      c;
        logic [3:0] op;
        logic       is_divmod;
        op        = op_low(ir);
        is_divmod = (op == OP_DIV) || (op == OP_MOD);
        c         = '0;
        c.addr_a  = ir[DATA_W-OPCODE_W-1 -: REG_ADDR_W];
        c.addr_b  = ir[DATA_W-OPCODE_W-REG_ADDR_W-1 -: REG_ADDR_W];
        c.addr_c  = ir[DATA_W-OPCODE_W-2*REG_ADDR_W-1 -: REG_ADDR_W];
        case (st)
            S_FETCH:  c.imem_req = 1'b1;
            S_DECODE: begin
                c.pc_inc     = 1'b1;
                c.illegal_op = is_illegal(ir);
            end
            S_EXEC: begin
                c.alu_op    = alu_op_of(op);
                c.im_en     = (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SW) || (op == OP_LW);
                c.alu_start = is_divmod;
                c.reg_we    = (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) || (op == OP_SUBI) ||
                              (op == OP_MULT) || (op == OP_NAND) || (op == OP_LT) || (op == OP_LTE);
            end
            S_ALU_WAIT: c.alu_op = alu_op_of(op);
            // Keep the address operands selected for the whole memory access.
            S_MEM: begin
                c.alu_op   = alu_op_of(op);
                c.im_en    = 1'b1;
                c.dmem_req = 1'b1;
                c.dmem_we  = (op == OP_SW);
            end
            S_WB: begin
                c.reg_we = 1'b1;
                c.wb_sel = (op == OP_LW);
                c.alu_op = is_divmod ? alu_op_of(op) : {ALU_OP_W{1'b0}};
            end
            S_TAKEN:  c.pc_load = 1'b1;
            default:  c.imem_req = 1'b0;
        endcase
        c.addr_a = c.im_en ? {REG_ADDR_W{1'b0}} : c.addr_a;
        return c;
    endfunction

    assign op_s      = op_low(ir_r);
    assign illegal_s = is_illegal(ir_r);

    // Next-state and next-IR selection.
    always_comb begin
        state_nxt_s = state_r;
        ir_nxt_s    = ir_r;
        case (state_r)
            S_IDLE: state_nxt_s = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    ir_nxt_s    = instr;
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (illegal_s) begin
                    state_nxt_s = S_FETCH;
                end else if (op_s == OP_JUMP) begin
                    state_nxt_s = S_TAKEN;
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_s)
                    OP_DIV, OP_MOD: state_nxt_s = S_ALU_WAIT;
                    OP_SW, OP_LW:   state_nxt_s = S_MEM;
                    OP_BLT:         state_nxt_s = alu_lt  ? S_TAKEN : S_FETCH;
                    OP_BGE:         state_nxt_s = !alu_lt ? S_TAKEN : S_FETCH;
                    OP_BEQ:         state_nxt_s = alu_eq  ? S_TAKEN : S_FETCH;
                    default:        state_nxt_s = S_FETCH;
                endcase
            end
            S_ALU_WAIT: state_nxt_s = alu_done ? S_WB : S_ALU_WAIT;
            S_MEM: begin
                if (dmem_ready) begin
                    state_nxt_s = (op_s == OP_LW) ? S_WB : S_FETCH;
                end else begin
                    state_nxt_s = S_MEM;
                end
            end
            S_WB:    state_nxt_s = S_FETCH;
            S_TAKEN: state_nxt_s = S_FETCH;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode for the state being entered.
    always_comb begin
        ctrl_nxt_s = ctrl_of(state_nxt_s, ir_nxt_s);
    end

    // State, IR and registered outputs; reset aborts any handshake at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            ir_r    <= {DATA_W{1'b0}};
            ctrl_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            ir_r    <= ir_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
        end
    end

    assign imem_req   = ctrl_r.imem_req;
    assign alu_start  = ctrl_r.alu_start;
    assign dmem_req   = ctrl_r.dmem_req;
    assign dmem_we    = ctrl_r.dmem_we;
    assign reg_addr_a = ctrl_r.addr_a;
    assign reg_addr_b = ctrl_r.addr_b;
    assign reg_addr_c = ctrl_r.addr_c;
    assign reg_we     = ctrl_r.reg_we;
    assign alu_op     = ctrl_r.alu_op;
    assign im_en      = ctrl_r.im_en;
    assign wb_sel     = ctrl_r.wb_sel;
    assign pc_inc     = ctrl_r.pc_inc;
    assign pc_load    = ctrl_r.pc_load;
    assign illegal_op = ctrl_r.illegal_op;
    assign state_dbg  = state_r;

endmodule
